hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operations issued from EX, iterates them over 32 cycles, and stalls the pipeline on HI/LO hazards. Its HI/LO outputs feed the R64_Hi/R64_Lo fields carried through EX/MEM and MEM/WB to the register-file write mux.

## Interface
Parameters:
- None. Data width is fixed at 32, product/HI:LO at 64.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- Start_In  in  1  issue request for the operation on Op_In/A_In/B_In.
- Op_In  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A_In  in  32  rs operand (multiplicand/dividend).
- B_In  in  32  rt operand (multiplier/divisor).
- Wr_Hi_In / Wr_Lo_In  in  1  MTHI / MTLO request.
- Wr_Data_In  in  32  data for MTHI/MTLO.
- Read_HiLo_In  in  1  MFHI/MFLO present in EX.
- Flush_In  in  1  abort in-flight operation (branch/exception flush).
- Stall_Out  out  1  freeze IF/ID/EX; combinational.
- Busy_Out  out  1  operation in flight.
- Done_Out  out  1  one-cycle completion pulse.
- Div_By_Zero_Out  out  1  sticky flag; last divide had B=0.
- R64_Hi_Out / R64_Lo_Out  out  32  architectural HI/LO.

## Operation
- States: IDLE, RUN, FIX, DONE. Reset: IDLE, HI=LO=0, count=0, all flags/outputs 0.
- Accept: Start_In=1 in IDLE or DONE and Flush_In=0 -> latch Op, operands, and sign info. Signed ops latch magnitudes. Go to RUN with count=0.
- RUN (multiply): radix-2 shift-add of unsigned magnitudes into a 64-bit accumulator, one bit per cycle.
- RUN (divide): restoring division, one quotient bit per cycle, 33-bit partial remainder.
- RUN exits when count=31 -> FIX.
- FIX: apply sign correction.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI (product[63:32] / remainder) and LO (product[31:0] / quotient). Go to DONE.
- DONE: Done_Out=1 for one cycle. Next state is IDLE, or RUN if a new Start is accepted.
- Divide by zero (B_In=0 on DIV/DIVU):
  - Normal latency; HI=A_In, LO=0xFFFFFFFF.
  - Div_By_Zero_Out set at the FIX edge; cleared on the next accepted Start.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0 (wraps, no flag).
- MTHI/MTLO:
  - Written at the edge when state is IDLE or DONE. An MTHI/MTLO issued in DONE overrides that op's FIX result.
  - If Start_In and Wr_* are asserted in the same cycle, Wr_* is applied first and the Start is accepted.
- Stall_Out = (Busy_Out) & (Start_In | Read_HiLo_In | Wr_Hi_In | Wr_Lo_In). Requests made while stalled are ignored; the pipeline holds them.
- Flush_In:
  - In RUN/FIX: go to IDLE; HI/LO and Div_By_Zero unchanged; no Done pulse.
  - In IDLE/DONE: suppresses acceptance of Start and Wr_*.
- RST in any state overrides all other inputs and returns to the reset values.

## Timing
- Start accepted at edge E0.
- Busy_Out=1 from E0 through E33 (states RUN and FIX).
- HI/LO updated at edge E33. Done_Out is high E33–E34.
- An MFHI in EX at cycle E33 reads the new value with no stall.
- Back-to-back: a Start in DONE is accepted at E34; the next result lands at E67.
- Stall_Out has zero-cycle latency from its inputs. Every other output is registered.

## Configuration
- HILO_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle 32x32 array multiply and skip RUN: E0 -> FIX, HI/LO written at E1, Done_Out high E1–E2.
  - Divide latency is unchanged.
- Undefined: all operations use the 32-cycle iterative path.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=7 -> at E33 HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done_Out for exactly one cycle; Busy_Out high 33 cycles.
- DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- DIVU A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF, Div_By_Zero_Out=1. Next accepted Start clears it.
- Read_HiLo_In=1 at E5 of a MULTU -> Stall_Out=1 until E33; then unstalled and HI/LO hold the product. Start_In during RUN -> Stall_Out=1, op not restarted.
- Flush_In at E10 of MULTU 5x5 (HI/LO previously 0xAAAA/0xBBBB) -> IDLE at E11, HI/LO unchanged, no Done pulse. RST at E20 of a DIV -> HI=LO=0 and IDLE at the next edge.
- With HILO_FAST_MUL_EN: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at E1 HI=0xFFFFFFFE, LO=0x00000001; Done_Out high E1–E2.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: pipeline-side request/response bundle for the HI/LO multiply/divide sequencer.
// master = pipeline (EX stage), slave = sequencer.
interface hilo_muldiv_ctrl_if;
  localparam int unsigned DW = 32;

  logic          Start_In;
  logic [1:0]    Op_In;
  logic [DW-1:0] A_In;
  logic [DW-1:0] B_In;
  logic          Wr_Hi_In;
  logic          Wr_Lo_In;
  logic [DW-1:0] Wr_Data_In;
  logic          Read_HiLo_In;
  logic          Flush_In;
  logic          Stall_Out;
  logic          Busy_Out;
  logic          Done_Out;
  logic          Div_By_Zero_Out;
  logic [DW-1:0] R64_Hi_Out;
  logic [DW-1:0] R64_Lo_Out;

  modport master (
    output Start_In, Op_In, A_In, B_In, Wr_Hi_In, Wr_Lo_In, Wr_Data_In,
           Read_HiLo_In, Flush_In,
    input  Stall_Out, Busy_Out, Done_Out, Div_By_Zero_Out, R64_Hi_Out, R64_Lo_Out
  );

  modport slave (
    input  Start_In, Op_In, A_In, B_In, Wr_Hi_In, Wr_Lo_In, Wr_Data_In,
           Read_HiLo_In, Flush_In,
    output Stall_Out, Busy_Out, Done_Out, Div_By_Zero_Out, R64_Hi_Out, R64_Lo_Out
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Optional feature macro: HILO_FAST_MUL_EN (single-cycle multiply, skips RUN).
module hilo_muldiv_ctrl (
  input  logic              CLK,
  input  logic              RST,
  hilo_muldiv_ctrl_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e        r_state;
  state_e        w_state_nxt;

  logic [CW-1:0] r_cnt,      w_cnt_nxt;
  logic [DW-1:0] r_acc_hi,   w_acc_hi_nxt;
  logic [DW-1:0] r_acc_lo,   w_acc_lo_nxt;
  logic [DW-1:0] r_opb,      w_opb_nxt;
  logic          r_is_div,   w_is_div_nxt;
  logic          r_neg_q,    w_neg_q_nxt;
  logic          r_neg_r,    w_neg_r_nxt;
  logic          r_dbz_pend, w_dbz_pend_nxt;
  logic [DW-1:0] r_hi,       w_hi_nxt;
  logic [DW-1:0] r_lo,       w_lo_nxt;
  logic          r_dbz,      w_dbz_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_done,     w_done_nxt;

  logic          w_open;
  logic          w_accept;
  logic          w_wr_ok;
  logic          w_op_signed;
  logic          w_op_div;
  logic          w_fast_mul;
  logic [DW-1:0] w_a_mag;
  logic [DW-1:0] w_b_mag;

  logic [DW:0]   w_mul_sum;
  logic [DW:0]   w_rem_sh;
  logic          w_q_bit;
  logic [DW-1:0] w_rem_sub;

  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_prod_sgn;
  logic [DW-1:0] w_quo;
  logic [DW-1:0] w_rem;
  logic [DW-1:0] w_fix_hi;
  logic [DW-1:0] w_fix_lo;

  // Issue window and operand decode
  assign w_open      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = w_open & bus.Start_In & ~bus.Flush_In;
  assign w_wr_ok     = w_open & ~bus.Flush_In;
  assign w_op_signed = bus.Op_In[0];
  assign w_op_div    = bus.Op_In[1];
  assign w_a_mag     = (w_op_signed & bus.A_In[DW-1]) ? (DW'(0) - bus.A_In) : bus.A_In;
  assign w_b_mag     = (w_op_signed & bus.B_In[DW-1]) ? (DW'(0) - bus.B_In) : bus.B_In;

`ifdef HILO_FAST_MUL_EN
  logic [PW-1:0] w_fast_prod;
  assign w_fast_mul  = ~w_op_div;
  assign w_fast_prod = PW'(w_a_mag) * PW'(w_b_mag);
`else
  assign w_fast_mul  = 1'b0;
`endif

  // One shift-add multiply step: multiplier in acc_lo, multiplicand in opb
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : (DW+1)'(0));

  // One restoring-division step: dividend bits shift out of acc_lo into the remainder
  assign w_rem_sh  = {r_acc_hi, r_acc_lo[DW-1]};
  assign w_q_bit   = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_sub = DW'(w_rem_sh - {1'b0, r_opb});

  // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_sgn = r_neg_q ? (PW'(0) - w_prod) : w_prod;
  assign w_quo      = r_dbz_pend ? '1 : (r_neg_q ? (DW'(0) - r_acc_lo) : r_acc_lo);
  assign w_rem      = r_neg_r ? (DW'(0) - r_acc_hi) : r_acc_hi;
  assign w_fix_hi   = r_is_div ? w_rem : w_prod_sgn[PW-1:DW];
  assign w_fix_lo   = r_is_div ? w_quo : w_prod_sgn[DW-1:0];

  // Hazard stall back to IF/ID/EX, zero-cycle latency
  assign bus.Stall_Out = r_busy & (bus.Start_In | bus.Read_HiLo_In | bus.Wr_Hi_In | bus.Wr_Lo_In);

  assign bus.Busy_Out        = r_busy;
  assign bus.Done_Out        = r_done;
  assign bus.Div_By_Zero_Out = r_dbz;
  assign bus.R64_Hi_Out      = r_hi;
  assign bus.R64_Lo_Out      = r_lo;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = w_fast_mul ? S_FIX : S_RUN;
        else          w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (bus.Flush_In)             w_state_nxt = S_IDLE;
        else if (r_cnt == LAST_CNT)   w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt = bus.Flush_In ? S_IDLE : S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_acc_hi_nxt   = r_acc_hi;
    w_acc_lo_nxt   = r_acc_lo;
    w_opb_nxt      = r_opb;
    w_is_div_nxt   = r_is_div;
    w_neg_q_nxt    = r_neg_q;
    w_neg_r_nxt    = r_neg_r;
    w_dbz_pend_nxt = r_dbz_pend;
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    w_dbz_nxt      = r_dbz;
    w_busy_nxt     = (w_state_nxt == S_RUN) || (w_state_nxt == S_FIX);
    w_done_nxt     = (w_state_nxt == S_DONE);

    case (r_state)
      S_IDLE, S_DONE: begin
        // MTHI/MTLO land before a same-cycle Start; a write in DONE overrides the FIX result
        if (w_wr_ok && bus.Wr_Hi_In) w_hi_nxt = bus.Wr_Data_In;
        if (w_wr_ok && bus.Wr_Lo_In) w_lo_nxt = bus.Wr_Data_In;
        if (w_accept) begin
          w_cnt_nxt      = '0;
          w_is_div_nxt   = w_op_div;
          w_neg_q_nxt    = w_op_signed & (bus.A_In[DW-1] ^ bus.B_In[DW-1]);
          w_neg_r_nxt    = w_op_signed & bus.A_In[DW-1];
          w_dbz_pend_nxt = w_op_div & (bus.B_In == '0);
          w_dbz_nxt      = 1'b0;
          w_acc_hi_nxt   = '0;
          if (w_op_div) begin
            w_acc_lo_nxt = w_a_mag;
            w_opb_nxt    = w_b_mag;
          end else begin
            w_acc_lo_nxt = w_b_mag;
            w_opb_nxt    = w_a_mag;
          end
`ifdef HILO_FAST_MUL_EN
          if (!w_op_div) {w_acc_hi_nxt, w_acc_lo_nxt} = w_fast_prod;
`endif
        end
      end
      S_RUN: begin
        if (!bus.Flush_In) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_is_div) begin
            w_acc_hi_nxt = w_q_bit ? w_rem_sub : DW'(w_rem_sh);
            w_acc_lo_nxt = {r_acc_lo[DW-2:0], w_q_bit};
          end else begin
            w_acc_hi_nxt = w_mul_sum[DW:1];
            w_acc_lo_nxt = {w_mul_sum[0], r_acc_lo[DW-1:1]};
          end
        end
      end
      S_FIX: begin
        if (!bus.Flush_In) begin
          w_hi_nxt = w_fix_hi;
          w_lo_nxt = w_fix_lo;
          if (r_is_div && r_dbz_pend) w_dbz_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opb      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dbz      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_acc_hi   <= w_acc_hi_nxt;
      r_acc_lo   <= w_acc_lo_nxt;
      r_opb      <= w_opb_nxt;
      r_is_div   <= w_is_div_nxt;
      r_neg_q    <= w_neg_q_nxt;
      r_neg_r    <= w_neg_r_nxt;
      r_dbz_pend <= w_dbz_pend_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_dbz      <= w_dbz_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed + random bench for hilo_muldiv_ctrl with an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;
  logic        clk;
  logic        rst;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dbz;

  hilo_muldiv_ctrl_if bus();

  hilo_muldiv_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00:   return 64'(ua * ub);
      2'b01:   return 64'(sa * sb);
      2'b10:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef HILO_FAST_MUL_EN
    return op[1] ? 33 : 1;
`else
    return (op == 2'b00) ? 33 : 33;
`endif
  endfunction

  // Issue one op (from IDLE or DONE), wait for Done, check timing and result
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] e;
    int lat;
    int bcnt;
    e = ref_op(op, a, b);
    bus.Op_In = op; bus.A_In = a; bus.B_In = b; bus.Start_In = 1'b1;
    tick;
    bus.Start_In = 1'b0; bus.Wr_Hi_In = 1'b0; bus.Wr_Lo_In = 1'b0;
    chk({tag, " busy@E0"}, 32'(bus.Busy_Out), 32'd1);
    chk({tag, " done@E0"}, 32'(bus.Done_Out), 32'd0);
    chk({tag, " dbz@E0"},  32'(bus.Div_By_Zero_Out), 32'd0);
    chk({tag, " hi@E0"},   bus.R64_Hi_Out, m_hi);
    chk({tag, " lo@E0"},   bus.R64_Lo_Out, m_lo);
    lat = 0; bcnt = 0;
    while (bus.Done_Out !== 1'b1 && lat < 100) begin
      if (bus.Busy_Out === 1'b1) bcnt++;
      tick;
      lat++;
    end
    m_hi = e[63:32]; m_lo = e[31:0]; m_dbz = op[1] && (b == 0);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat(op)));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_lat(op)));
    chk({tag, " hi"}, bus.R64_Hi_Out, m_hi);
    chk({tag, " lo"}, bus.R64_Lo_Out, m_lo);
    chk({tag, " dbz"}, 32'(bus.Div_By_Zero_Out), 32'(m_dbz));
    chk({tag, " busy_end"}, 32'(bus.Busy_Out), 32'd0);
  endtask

  initial begin
    logic [63:0] e;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat, dcnt;

    rst = 1'b1;
    bus.Start_In = 1'b0; bus.Op_In = 2'b00; bus.A_In = '0; bus.B_In = '0;
    bus.Wr_Hi_In = 1'b0; bus.Wr_Lo_In = 1'b0; bus.Wr_Data_In = '0;
    bus.Read_HiLo_In = 1'b0; bus.Flush_In = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    tick; tick;
    chk("rst hi",    bus.R64_Hi_Out, 32'h0);
    chk("rst lo",    bus.R64_Lo_Out, 32'h0);
    chk("rst busy",  32'(bus.Busy_Out), 32'd0);
    chk("rst done",  32'(bus.Done_Out), 32'd0);
    chk("rst dbz",   32'(bus.Div_By_Zero_Out), 32'd0);
    chk("rst stall", 32'(bus.Stall_Out), 32'd0);
    rst = 1'b0;
    tick;

    // Test-plan vectors; DIV issued back-to-back from DONE
    do_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7);
    chk("mult_m3x7 hi_const", bus.R64_Hi_Out, 32'hFFFF_FFFF);
    chk("mult_m3x7 lo_const", bus.R64_Lo_Out, 32'hFFFF_FFEB);
    do_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7d2 lo_const", bus.R64_Lo_Out, 32'hFFFF_FFFD);
    chk("div_m7d2 hi_const", bus.R64_Hi_Out, 32'hFFFF_FFFF);
    tick;
    do_op("divu_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("divu_m7d2 lo_const", bus.R64_Lo_Out, 32'h7FFF_FFFC);
    chk("divu_m7d2 hi_const", bus.R64_Hi_Out, 32'h0000_0001);
    tick;
    do_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0);
    chk("divu_by0 hi_const", bus.R64_Hi_Out, 32'h0000_1234);
    chk("divu_by0 lo_const", bus.R64_Lo_Out, 32'hFFFF_FFFF);
    chk("divu_by0 dbz_const", 32'(bus.Div_By_Zero_Out), 32'd1);
    tick;
    chk("dbz sticky idle", 32'(bus.Div_By_Zero_Out), 32'd1);
    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max hi_const", bus.R64_Hi_Out, 32'hFFFF_FFFE);
    chk("multu_max lo_const", bus.R64_Lo_Out, 32'h0000_0001);
    tick;
    do_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf lo_const", bus.R64_Lo_Out, 32'h8000_0000);
    chk("div_ovf hi_const", bus.R64_Hi_Out, 32'h0);
    tick;

    // MTHI / MTLO from IDLE
    bus.Wr_Hi_In = 1'b1; bus.Wr_Data_In = 32'h0000_AAAA; tick;
    bus.Wr_Hi_In = 1'b0; bus.Wr_Lo_In = 1'b1; bus.Wr_Data_In = 32'h0000_BBBB; tick;
    bus.Wr_Lo_In = 1'b0;
    m_hi = 32'h0000_AAAA; m_lo = 32'h0000_BBBB;
    chk("mthi idle", bus.R64_Hi_Out, m_hi);
    chk("mtlo idle", bus.R64_Lo_Out, m_lo);

    // Flush mid-RUN: no result, no Done
    bus.Op_In = 2'b00; bus.A_In = 32'd5; bus.B_In = 32'd5; bus.Start_In = 1'b1;
    tick;
    bus.Start_In = 1'b0;
    repeat (9) tick;
    bus.Flush_In = 1'b1;
    tick;
    bus.Flush_In = 1'b0;
    chk("flush busy", 32'(bus.Busy_Out), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done_Out === 1'b1) dcnt++;
      tick;
    end
    chk("flush no_done", 32'(dcnt), 32'd0);
    chk("flush hi", bus.R64_Hi_Out, m_hi);
    chk("flush lo", bus.R64_Lo_Out, m_lo);

    // Flush in IDLE suppresses Start and MTHI
    bus.Flush_In = 1'b1; bus.Start_In = 1'b1; bus.Wr_Hi_In = 1'b1; bus.Wr_Data_In = 32'hDEAD;
    tick;
    bus.Flush_In = 1'b0; bus.Start_In = 1'b0; bus.Wr_Hi_In = 1'b0;
    chk("idle_flush busy", 32'(bus.Busy_Out), 32'd0);
    chk("idle_flush hi", bus.R64_Hi_Out, m_hi);

    // HI/LO read hazard stall and Start during RUN
`ifdef HILO_FAST_MUL_EN
    op = 2'b10;
`else
    op = 2'b00;
`endif
    e = ref_op(op, 32'h1234_5678, 32'h9ABC_DEF0);
    bus.Op_In = op; bus.A_In = 32'h1234_5678; bus.B_In = 32'h9ABC_DEF0; bus.Start_In = 1'b1;
    tick;
    bus.Start_In = 1'b0;
    repeat (4) tick;
    bus.Read_HiLo_In = 1'b1;
    #1;
    chk("read stall", 32'(bus.Stall_Out), 32'd1);
    tick;
    bus.Op_In = 2'b11; bus.A_In = 32'd7; bus.B_In = 32'd1; bus.Start_In = 1'b1;
    #1;
    chk("start stall", 32'(bus.Stall_Out), 32'd1);
    tick;
    bus.Start_In = 1'b0;
    lat = 6;
    while (bus.Stall_Out === 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    m_hi = e[63:32]; m_lo = e[31:0];
    chk("stall release", 32'(lat), 32'd33);
    chk("stall done", 32'(bus.Done_Out), 32'd1);
    chk("stall hi", bus.R64_Hi_Out, m_hi);
    chk("stall lo", bus.R64_Lo_Out, m_lo);
    bus.Read_HiLo_In = 1'b0;
    tick;
    chk("no restart busy", 32'(bus.Busy_Out), 32'd0);
    chk("no restart done", 32'(bus.Done_Out), 32'd0);

    // MTHI in DONE overrides that op's HI
    do_op("mthi_done", 2'b01, 32'd100, 32'hFFFF_FFFD);
    bus.Wr_Hi_In = 1'b1; bus.Wr_Data_In = 32'h0BAD_F00D;
    tick;
    bus.Wr_Hi_In = 1'b0;
    m_hi = 32'h0BAD_F00D;
    chk("mthi_done hi", bus.R64_Hi_Out, m_hi);
    chk("mthi_done lo", bus.R64_Lo_Out, m_lo);

    // MTLO and Start in the same cycle: write first, op still accepted
    bus.Wr_Lo_In = 1'b1; bus.Wr_Data_In = 32'h0000_5555;
    m_lo = 32'h0000_5555;
    do_op("wr_and_start", 2'b00, 32'd2, 32'd3);
    tick;

    // Synchronous reset mid-DIV
    bus.Op_In = 2'b11; bus.A_In = 32'hFFFF_FF9C; bus.B_In = 32'd7; bus.Start_In = 1'b1;
    tick;
    bus.Start_In = 1'b0;
    repeat (19) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    chk("midrst hi",   bus.R64_Hi_Out, 32'h0);
    chk("midrst lo",   bus.R64_Lo_Out, 32'h0);
    chk("midrst busy", 32'(bus.Busy_Out), 32'd0);
    chk("midrst done", 32'(bus.Done_Out), 32'd0);
    tick;
    chk("midrst idle", 32'(bus.Busy_Out), 32'd0);

    // Random operations
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      do_op("rand", op, a, b);
      if ($urandom_range(0, 1) == 0) tick;
    end
    tick;
    chk("final done", 32'(bus.Done_Out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
